// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: latches two operands, streams them LSB first
// through a single full-adder cell with a carry flip-flop, and gathers the parallel result.
module serial_adder_ctrl #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] s_sh_q;
  logic [WIDTH-1:0] s_sh_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH:0]   s_cat;

  full_adder u_fa (
    .x_i (a_sh_q[0]),
    .y_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Shift via a WIDTH+1 concatenation so the WIDTH=1 case needs no empty slice.
  always_comb begin
    s_cat  = {fa_s, s_sh_q};
    s_sh_d = s_cat[WIDTH:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so the carry seeds to 1 and c_in is ignored.
            a_sh_q  <= a;
            b_sh_q  <= sub ? ~b : b;
            carry_q <= sub | c_in;
            cnt_q   <= '0;
            s_sh_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= s_sh_d;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            sum_q   <= s_sh_d;
            c_out_q <= fa_c;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// Lab full-adder cell driven by the controller above.
module full_adder (
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i ^ c_i;
  assign c_o = (x_i & y_i) | (c_i & (x_i ^ y_i));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, co8;
  logic [7:0] sum8;
  logic       start1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, co1;
  logic [0:0] sum1;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [7:0]  prev_sum8, prev_sum1;
  logic        prev_co8, prev_co1;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .c_in(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8), .c_out(co8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .c_in(cin1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .c_out(co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {carry/no-borrow, result} using plain integer arithmetic.
  function automatic logic [8:0] model(input int unsigned w, input logic [7:0] x,
                                       input logic [7:0] y, input bit s, input bit c);
    int unsigned m, xa, ya, t;
    m  = 1 << w;
    xa = int'(x) % m;
    ya = int'(y) % m;
    if (s) begin
      t = (xa + m - ya) % m;
      return {xa >= ya, 8'(t)};
    end
    t = xa + ya + int'(c);
    return {t >= m, 8'(t % m)};
  endfunction

  function automatic logic [31:0] obs_busy(input bit sel);
    return 32'(sel ? busy1 : busy8);
  endfunction
  function automatic logic [31:0] obs_done(input bit sel);
    return 32'(sel ? done1 : done8);
  endfunction
  function automatic logic [31:0] obs_sum(input bit sel);
    return sel ? 32'(sum1) : 32'(sum8);
  endfunction
  function automatic logic [31:0] obs_co(input bit sel);
    return 32'(sel ? co1 : co8);
  endfunction

  task automatic drive(input bit sel, input bit st, input logic [7:0] ta,
                       input logic [7:0] tb_, input bit ts, input bit tc);
    if (sel) begin
      start1 = st; a1 = ta[0:0]; b1 = tb_[0:0]; sub1 = ts; cin1 = tc;
    end else begin
      start8 = st; a8 = ta; b8 = tb_; sub8 = ts; cin8 = tc;
    end
  endtask

  task automatic scramble(input bit sel, input bit hold);
    drive(sel, hold, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One operation: start sampled at the next rising edge (E0); done expected at E0+w.
  task automatic op(input bit sel, input logic [7:0] ta, input logic [7:0] tb_,
                    input bit ts, input bit tc, input bit hold, input bit fresh);
    int unsigned w;
    logic [8:0]  e;
    logic [7:0]  psum;
    logic        pco;
    w    = sel ? 1 : 8;
    e    = model(w, ta, tb_, ts, tc);
    psum = sel ? prev_sum1 : prev_sum8;
    pco  = sel ? prev_co1 : prev_co8;
    if (fresh) @(negedge clk);
    drive(sel, 1'b1, ta, tb_, ts, tc);
    @(posedge clk); #1;
    check("busy_E0", obs_busy(sel), 1);
    check("done_E0", obs_done(sel), 0);
    for (int unsigned k = 1; k <= w + 1; k++) begin
      scramble(sel, hold);
      @(posedge clk); #1;
      if (k < w) begin
        check("busy_run", obs_busy(sel), 1);
        check("done_run", obs_done(sel), 0);
        check("sum_hold", obs_sum(sel), 32'(psum));
        check("co_hold", obs_co(sel), 32'(pco));
      end else if (k == w) begin
        check("done_pulse", obs_done(sel), 1);
        check("busy_done", obs_busy(sel), 1);
        check("sum", obs_sum(sel), 32'(e[7:0]));
        check("c_out", obs_co(sel), 32'(e[8]));
        if (sel) begin prev_sum1 = e[7:0]; prev_co1 = e[8]; end
        else begin prev_sum8 = e[7:0]; prev_co8 = e[8]; end
      end else begin
        check("done_fall", obs_done(sel), 0);
        check("busy_fall", obs_busy(sel), 0);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    prev_sum8 = '0; prev_co8 = 1'b0;
    prev_sum1 = '0; prev_co1 = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy8", obs_busy(1'b0), 0);
    check("rst_done8", obs_done(1'b0), 0);
    check("rst_sum8", obs_sum(1'b0), 0);
    check("rst_co8", obs_co(1'b0), 0);
    check("rst_busy1", obs_busy(1'b1), 0);
    check("rst_sum1", obs_sum(1'b1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(1'b0, 8'h3C, 8'h25, 1'b0, 1'b0, 1'b0, 1'b1);
    op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    op(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    op(1'b0, 8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    op(1'b0, 8'h07, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1);
    op(1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    start8 = 1'b0;

    for (int i = 0; i < 20; i++)
      op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);

    // Abort mid-RUN after three bits.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h5A, 8'h33, 1'b0, 1'b0);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", obs_busy(1'b0), 0);
    check("abort_done", obs_done(1'b0), 0);
    check("abort_sum", obs_sum(1'b0), 0);
    check("abort_co", obs_co(1'b0), 0);
    prev_sum8 = '0; prev_co8 = 1'b0;
    prev_sum1 = '0; prev_co1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", obs_done(1'b0), 0);
    end
    op(1'b0, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op(1'b1, {7'b0, v[2]}, {7'b0, v[1]}, 1'b0, v[0], 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      op(1'b1, {7'b0, v[1]}, {7'b0, v[0]}, 1'b1, 1'($urandom), 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
